// File: rtl/call_return_stack.sv
// call_return_stack
//
// Hardware return-address stack for the multicycle core. It sits directly
// after the ID control unit and acts on that unit's push, pop and strobe
// signals.
// - A CALL pushes the return PC onto the stack.
// - A RET pops the stack. The popped PC is held on ret_addr for the PC-source
//   mux until the PC write stage.
// - Sticky overflow and underflow flags are provided for debug.
//
// Ports:
//   clk          core clock; all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   push         push request (CALL)
//   pop          pop request (RET)
//   push_pop_en  stage strobe that qualifies push/pop; one operation per assertion
//   data_in      return address to store (PC+1 from IF)
//   ret_addr     registered value of the last popped entry
//   top          combinational peek of the top entry; 0 when the stack is empty
//   count        number of valid entries, 0..DEPTH
//   empty        count == 0
//   full         count == DEPTH
//   overflow     sticky: a push was attempted while full
//   underflow    sticky: a pop was attempted while empty
//
// DEPTH must equal 2**ADDR_W. The pointer arithmetic relies on that.
module call_return_stack #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              push_pop_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] ret_addr,
    output logic [DATA_W-1:0] top,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              armed;
    logic              fire;
    logic [ADDR_W-1:0] top_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic              mem_we;
    logic [DATA_W-1:0] top_entry;

    assign fire  = push_pop_en & armed;
    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // Low bits of count minus one. This also gives the correct index when
    // count == DEPTH, because the low bits are then 0 and the result is DEPTH-1.
    assign top_idx   = count[ADDR_W-1:0] - 1'b1;
    assign top_entry = mem[top_idx];
    assign top       = empty ? '0 : top_entry;

    // Write port.
    // - Plain push writes the slot above the top.
    // - Swap overwrites the top in place.
    // - Push+pop on an empty stack degrades to a push at slot 0. Slot 0 is
    //   count's low bits when count is 0.
    always_comb begin
        mem_we = 1'b0;
        wr_idx = count[ADDR_W-1:0];
        if (fire && push) begin
            if (pop) begin
                mem_we = 1'b1;
                wr_idx = empty ? count[ADDR_W-1:0] : top_idx;
            end else begin
                mem_we = !full;
            end
        end
    end

    // Storage is intentionally not reset; entries above count are don't-care.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            ret_addr  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            armed     <= 1'b1;
        end else begin
            // Re-arm whenever the strobe is low. While the strobe stays high,
            // armed is cleared by the firing edge and then stays clear.
            armed <= ~push_pop_en;
            if (fire) begin
                case ({push, pop})
                    2'b10: begin
                        if (full) begin
                            overflow <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    2'b01: begin
                        if (empty) begin
                            underflow <= 1'b1;
                        end else begin
                            ret_addr <= top_entry;
                            count    <= count - 1'b1;
                        end
                    end
                    2'b11: begin
                        if (empty) begin
                            underflow <= 1'b1;
                            count     <= count + 1'b1;
                        end else begin
                            ret_addr <= top_entry;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_call_return_stack.sv
module tb_call_return_stack;

    logic        clk;
    logic        reset;
    logic        push;
    logic        pop;
    logic        push_pop_en;
    logic [31:0] data_in;
    logic [31:0] ret_addr;
    logic [31:0] top;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;
        logic        en;
        logic        psh;
        logic        pp;
        logic [31:0] din;
        logic [3:0]  c;
        logic [31:0] t;
        logic [31:0] r;
        logic        e;
        logic        f;
        logic        o;
        logic        u;
    } vec_t;

    vec_t vecs[$];

    call_return_stack #(.DATA_W(32), .ADDR_W(3), .DEPTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .push_pop_en (push_pop_en),
        .data_in     (data_in),
        .ret_addr    (ret_addr),
        .top         (top),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic void add(logic rst, logic en, logic psh, logic pp, logic [31:0] din,
                                logic [3:0] c, logic [31:0] t, logic [31:0] r,
                                logic e, logic f, logic o, logic u);
        vec_t v;
        v.rst = rst; v.en = en; v.psh = psh; v.pp = pp; v.din = din;
        v.c = c; v.t = t; v.r = r; v.e = e; v.f = f; v.o = o; v.u = u;
        vecs.push_back(v);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_state(string nm, logic [3:0] c, logic [31:0] t, logic [31:0] r,
                             logic e, logic f, logic o, logic u);
        chk({nm, " count"}, 32'(count), 32'(c));
        chk({nm, " top"}, top, t);
        chk({nm, " ret_addr"}, ret_addr, r);
        chk({nm, " empty"}, 32'(empty), 32'(e));
        chk({nm, " full"}, 32'(full), 32'(f));
        chk({nm, " overflow"}, 32'(overflow), 32'(o));
        chk({nm, " underflow"}, 32'(underflow), 32'(u));
    endtask

    // One cycle: drive on the falling edge, let the rising edge act, sample 1ns later.
    task automatic cyc(logic en, logic psh, logic pp, logic [31:0] din);
        @(negedge clk);
        push_pop_en = en; push = psh; pop = pp; data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; push_pop_en = 1'b0; push = 1'b0; pop = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; push_pop_en = 1'b0; data_in = '0;

        // ---------------- vector table ----------------
        //  rst en psh pp  din            c  top       ret       e  f  o  u
        add(1, 0, 0, 0, 32'h0,         0, 32'h0,  32'h0,  1, 0, 0, 0);
        add(0, 1, 1, 0, 32'h40,        1, 32'h40, 32'h0,  0, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,         1, 32'h40, 32'h0,  0, 0, 0, 0);
        add(0, 1, 0, 1, 32'h0,         0, 32'h0,  32'h40, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            add(0, 0, 0, 0, 32'h0,     0, 32'h0,  32'h40, 1, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            add(0, 1, 1, 0, 32'(i*16), 4'(i), 32'(i*16), 32'h40, 0, (i == 8), 0, 0);
            add(0, 0, 0, 0, 32'h0,     4'(i), 32'(i*16), 32'h40, 0, (i == 8), 0, 0);
        end
        add(0, 1, 1, 0, 32'h90,        8, 32'h80, 32'h40, 0, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0,         8, 32'h80, 32'h40, 0, 1, 1, 0);
        for (int i = 8; i >= 1; i--) begin
            add(0, 1, 0, 1, 32'h0,     4'(i-1), 32'((i-1)*16), 32'(i*16), (i == 1), 0, 1, 0);
            add(0, 0, 0, 0, 32'h0,     4'(i-1), 32'((i-1)*16), 32'(i*16), (i == 1), 0, 1, 0);
        end
        add(0, 1, 0, 1, 32'h0,         0, 32'h0,  32'h10, 1, 0, 1, 1);
        add(0, 0, 0, 0, 32'h0,         0, 32'h0,  32'h10, 1, 0, 1, 1);
        add(0, 1, 1, 0, 32'h55,        1, 32'h55, 32'h10, 0, 0, 1, 1);
        add(0, 0, 0, 0, 32'h0,         1, 32'h55, 32'h10, 0, 0, 1, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; push_pop_en = vecs[i].en;
            push = vecs[i].psh; pop = vecs[i].pp; data_in = vecs[i].din;
            @(posedge clk);
            #1;
            chk_state($sformatf("vec%0d", i), vecs[i].c, vecs[i].t, vecs[i].r,
                      vecs[i].e, vecs[i].f, vecs[i].o, vecs[i].u);
        end

        // ---------------- held strobe: one operation per assertion ----------------
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 0, 32'hAA);
            chk_state($sformatf("hold%0d", k), 1, 32'hAA, 32'h0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 32'h0);
        chk_state("hold_drop", 1, 32'hAA, 32'h0, 0, 0, 0, 0);
        cyc(1, 1, 0, 32'hBB);
        chk_state("hold_rearm", 2, 32'hBB, 32'h0, 0, 0, 0, 0);

        // ---------------- swap ----------------
        do_reset();
        cyc(1, 1, 0, 32'h11);
        cyc(0, 0, 0, 32'h0);
        cyc(1, 1, 0, 32'h22);
        cyc(0, 0, 0, 32'h0);
        chk_state("swap_pre", 2, 32'h22, 32'h0, 0, 0, 0, 0);
        cyc(1, 1, 1, 32'h33);
        chk_state("swap", 2, 32'h33, 32'h22, 0, 0, 0, 0);

        // ---------------- async reset mid-strobe ----------------
        // The strobe is still high from the swap, so armed is clear. Reset
        // must re-arm, so the strobe fires on the first edge after release.
        @(negedge clk);
        push_pop_en = 1'b1; push = 1'b1; pop = 1'b0; data_in = 32'h77;
        #2;
        reset = 1'b1;
        #1;
        chk_state("async_rst", 0, 32'h0, 32'h0, 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_state("post_rst_fire", 1, 32'h77, 32'h0, 0, 0, 0, 0);

        // ---------------- push+pop on an empty stack ----------------
        do_reset();
        cyc(1, 1, 1, 32'h66);
        chk_state("swap_empty", 1, 32'h66, 32'h0, 0, 0, 0, 1);
        cyc(0, 0, 0, 32'h0);
        cyc(1, 0, 1, 32'h0);
        chk_state("pop_after_swap_empty", 0, 32'h0, 32'h66, 1, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
